// File: rtl/scc_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encodings and
// default address/data widths.
package scc_mem_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_CMD = 2'd1,
    DM_CMD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while an eligible fetch waits; raises
// fetch_pri once the count reaches STARVE_MAX so fetch wins the next arbitration.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic dm_win,
  input  logic if_win,
  input  logic if_req,
  input  logic if_pend,
  output logic fetch_pri
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!clk_en) begin
      cnt_d = cnt_q;
    end else if (if_win || !if_req) begin
      cnt_d = 4'd0;
    end else if (dm_win && if_pend && (cnt_q < 4'(STARVE_MAX))) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_pri = (cnt_q >= 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch break data priority.
module mem_port_arbiter
  import scc_mem_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          halt_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    state_q, state_d;
  logic          if_ok, dm_win, if_win, fetch_pri;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

  // halt_f is sampled combinationally so a halt arriving with a fetch win blocks it
  always_comb begin
    if_ok  = if_req & ~halt_f;
    dm_win = dm_req & ~(fetch_pri & if_ok);
    if_win = if_ok & ~dm_win;
  end

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_cnt (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .dm_win    (dm_win),
    .if_win    (if_win),
    .if_req    (if_req),
    .if_pend   (if_ok),
    .fetch_pri (fetch_pri)
  );
`else
  // Constant low for any legal STARVE_MAX: data keeps strict priority.
  assign fetch_pri = (STARVE_MAX < 1);
`endif

  always_comb begin
    state_d = state_q;
    if (!clk_en) begin
      state_d = state_q;
    end else if (dm_win) begin
      state_d = DM_CMD;
    end else if (if_win) begin
      state_d = IF_CMD;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch and read-return pipeline; memory data is captured at the end of the command cycle
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_valid_d = if_valid_q;
    dm_valid_d = dm_valid_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (clk_en) begin
      if (dm_win) begin
        addr_d  = dm_addr;
        wdata_d = dm_wdata;
        we_d    = dm_we;
      end else if (if_win) begin
        addr_d = if_addr;
        we_d   = 1'b0;
      end else begin
        addr_d = addr_q;
      end
      if_valid_d = (state_q == IF_CMD);
      dm_valid_d = (state_q == DM_CMD) && !we_q;
      if (state_q == IF_CMD) begin
        if_rdata_d = mem_rdata;
      end else if (state_q == DM_CMD && !we_q) begin
        dm_rdata_d = mem_rdata;
      end else begin
        if_rdata_d = if_rdata_q;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      IF_CMD: begin
        if_gnt   = 1'b1;
        mem_read = 1'b1;
      end
      DM_CMD: begin
        dm_gnt    = 1'b1;
        mem_read  = ~we_q;
        mem_write = we_q;
      end
      default: begin
        if_gnt = 1'b0;
      end
    endcase
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_valid  = if_valid_q;
    dm_valid  = dm_valid_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grant and
// valid events, a negedge monitor pops and compares them on enabled cycles.
module tb_mem_port_arbiter;

  localparam int K_IF_GNT = 1;
  localparam int K_DM_RD  = 2;
  localparam int K_DM_WR  = 3;
  localparam int K_IF_VAL = 4;
  localparam int K_DM_VAL = 5;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, clk_en, halt_f;
  logic        if_req, if_gnt, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_valid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  ev_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          prev_g = 0;
  logic [31:0] prev_addr = 32'd0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : ~a;
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record what the current arbitration cycle must produce, then advance one edge.
  task automatic step(input int g);
    if (prev_g == 1) push(K_IF_VAL, prev_addr, mem_model(prev_addr));
    else if (prev_g == 2) push(K_DM_VAL, prev_addr, mem_model(prev_addr));
    case (g)
      1: begin push(K_IF_GNT, if_addr, 32'd0); prev_addr = if_addr; end
      2: begin push(K_DM_RD, dm_addr, 32'd0); prev_addr = dm_addr; end
      3: begin push(K_DM_WR, dm_addr, dm_wdata); prev_addr = dm_addr; end
      default: ;
    endcase
    prev_g = g;
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_ev(input int obs);
    ev_t  e;
    logic bad;
    logic [31:0] act_data;
    vectors++;
    act_data = (obs == K_IF_VAL) ? if_rdata : (obs == K_DM_VAL) ? dm_rdata : mem_wdata;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, expected no event", obs, mem_addr, act_data);
    end else begin
      e   = exp_q.pop_front();
      bad = (e.kind != obs);
      case (obs)
        K_IF_GNT, K_DM_RD: bad = bad || (mem_addr !== e.addr) || !mem_read || mem_write;
        K_DM_WR:  bad = bad || (mem_addr !== e.addr) || (mem_wdata !== e.data) || !mem_write || mem_read;
        K_IF_VAL: bad = bad || (if_rdata !== e.data);
        K_DM_VAL: bad = bad || (dm_rdata !== e.data);
        default:  bad = 1'b1;
      endcase
      if (bad) begin
        miscompares++;
        $display("FAIL event: got kind=%0d addr=%h data=%h rd=%b wr=%b, expected kind=%0d addr=%h data=%h",
                 obs, mem_addr, act_data, mem_read, mem_write, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every enabled cycle, compare presented events against the scoreboard.
  always @(negedge clk) begin
    if (!rst && clk_en) begin
      vectors++;
      if ((mem_read && mem_write) || (!if_gnt && !dm_gnt && (mem_read || mem_write))) begin
        miscompares++;
        $display("FAIL cmd_excl: got rd=%b wr=%b gnt=%b%b, expected at most one command and only with a grant",
                 mem_read, mem_write, if_gnt, dm_gnt);
      end
      if (if_valid) check_ev(K_IF_VAL);
      if (dm_valid) check_ev(K_DM_VAL);
      if (if_gnt)   check_ev(K_IF_GNT);
      if (dm_gnt)   check_ev(mem_write ? K_DM_WR : K_DM_RD);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; halt_f = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt",  {30'd0, if_gnt, dm_gnt}, 32'd0);
    chk("rst_val",  {30'd0, if_valid, dm_valid}, 32'd0);
    chk("rst_cmd",  {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdat", if_rdata | dm_rdata | mem_wdata, 32'd0);
    tick();
    rst = 1'b0;

    // Single fetch of 0x10
    if_req = 1'b1; if_addr = 32'h10; step(1);
    if_req = 1'b0; step(0); step(0);

    // Fetch and data read together: data first
    if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; step(2);
    dm_req = 1'b0; step(1);
    if_req = 1'b0; step(0); step(0);

    // Data write, no valid
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678; step(3);
    dm_req = 1'b0; dm_we = 1'b0; step(0); step(0);

    // Both held: starvation pattern with the guard, strict data priority without
    if_req = 1'b1; if_addr = 32'h24; dm_req = 1'b1; dm_addr = 32'h44;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      step(((k % 5) == 4) ? 1 : 2);
`else
      step(2);
`endif
    end
    if_req = 1'b0; dm_req = 1'b0; step(0); step(0);

    // Halt blocks fetch, data still serviced
    halt_f = 1'b1; if_req = 1'b1; if_addr = 32'h30; dm_req = 1'b1; dm_addr = 32'h50; step(2);
    dm_req = 1'b0; step(0); step(0); step(0);
    if_req = 1'b0; halt_f = 1'b0; step(0);

    // Halt rising after a fetch grant: fetch completes, no second grant
    if_req = 1'b1; if_addr = 32'h34; step(1);
    halt_f = 1'b1; step(0); step(0);
    if_req = 1'b0; halt_f = 1'b0; step(0);

    // clk_en low holds the command, then holds the pending valid
    if_req = 1'b1; if_addr = 32'h10; step(1);
    if_req = 1'b0; clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_gnt",  {31'd0, if_gnt & mem_read}, 32'd1);
      chk("hold_addr", mem_addr, 32'h10);
      tick();
    end
    clk_en = 1'b1; step(0);
    clk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold_val",  {31'd0, if_valid}, 32'd1);
      chk("hold_rdat", if_rdata, 32'hDEAD_BEEF);
      tick();
    end
    clk_en = 1'b1; step(0); step(0);

    // Reset in the middle of a fetch command
    if_req = 1'b1; if_addr = 32'h18; step(1);
    if_req = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_gnt",  {30'd0, if_gnt, mem_read}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_rdat", if_rdata, 32'd0);
    exp_q.delete();
    prev_g = 0;
    tick(); tick();
    rst = 1'b0;
    step(0); step(0); step(0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
